cordic_gain_comp4x2: RTL

Downstream stage of the 4-lane shared-control CORDIC rotator. It captures the eight final rotator outputs (x/y of lanes 0-3) and multiplies each by the CORDIC gain compensation constant K ≈ 0.6072529, so that SVD datapath values keep unit scale. The multiply is done iteratively with a fixed shift-add schedule, one term per cycle, on all eight values in parallel. The results are presented on a valid/ready output handshake.

---
 rtl/cordic_gain_comp4x2.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cordic_gain_comp4x2.sv
// Scales the eight final rotator outputs by the CORDIC gain K using a fixed
// seven-term shift-add schedule, all lanes in parallel, with a valid/ready output.
module cordic_gain_comp4x2 #(
    parameter int WIDTH = 24,
    parameter int GUARD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in0,
    input  logic [WIDTH-1:0] x_in1,
    input  logic [WIDTH-1:0] x_in2,
    input  logic [WIDTH-1:0] x_in3,
    input  logic [WIDTH-1:0] y_in0,
    input  logic [WIDTH-1:0] y_in1,
    input  logic [WIDTH-1:0] y_in2,
    input  logic [WIDTH-1:0] y_in3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out0,
    output logic [WIDTH-1:0] x_out1,
    output logic [WIDTH-1:0] x_out2,
    output logic [WIDTH-1:0] x_out3,
    output logic [WIDTH-1:0] y_out0,
    output logic [WIDTH-1:0] y_out1,
    output logic [WIDTH-1:0] y_out2,
    output logic [WIDTH-1:0] y_out3
);

    localparam int ACCW  = WIDTH + GUARD;
    localparam int LANES = 8;

    typedef enum logic [1:0] {IDLE, SCALE, OUT} state_t;

    state_t                  r_state;
    logic [2:0]              r_k;
    logic                    r_inReady;
    logic                    r_outValid;
    logic signed [WIDTH-1:0] r_val    [LANES];
    logic signed [ACCW-1:0]  r_acc    [LANES];
    logic [WIDTH-1:0]        r_res    [LANES];

    logic [WIDTH-1:0]        w_in     [LANES];
    logic signed [ACCW-1:0]  w_accNext[LANES];
    logic [WIDTH-1:0]        w_round  [LANES];
    logic [4:0]              w_shift;
    logic                    w_neg;

    assign w_in[0] = x_in0;
    assign w_in[1] = x_in1;
    assign w_in[2] = x_in2;
    assign w_in[3] = x_in3;
    assign w_in[4] = y_in0;
    assign w_in[5] = y_in1;
    assign w_in[6] = y_in2;
    assign w_in[7] = y_in3;

    // Shift/sign schedule giving K = 0.6072540283 when all seven terms are summed
    always_comb begin
        w_shift = 5'd1;
        w_neg   = 1'b0;
        case (r_k)
            3'd0: begin w_shift = 5'd1;  w_neg = 1'b0; end
            3'd1: begin w_shift = 5'd3;  w_neg = 1'b0; end
            3'd2: begin w_shift = 5'd6;  w_neg = 1'b1; end
            3'd3: begin w_shift = 5'd9;  w_neg = 1'b1; end
            3'd4: begin w_shift = 5'd12; w_neg = 1'b1; end
            3'd5: begin w_shift = 5'd14; w_neg = 1'b0; end
            3'd6: begin w_shift = 5'd16; w_neg = 1'b0; end
            default: begin w_shift = 5'd1; w_neg = 1'b0; end
        endcase
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [ACCW-1:0] w_ext;
        logic signed [ACCW-1:0] w_term;

        assign w_ext  = {r_val[g], {GUARD{1'b0}}};
        assign w_term = w_ext >>> w_shift;
        assign w_accNext[g] = w_neg ? (r_acc[g] - w_term) : (r_acc[g] + w_term);
        // Round half up on the final sum; |K| < 1 so this cannot wrap
        assign w_round[g] = w_accNext[g][ACCW-1:GUARD] + WIDTH'(w_accNext[g][GUARD-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_k        <= 3'd0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_val[i] <= '0;
                r_acc[i] <= '0;
                r_res[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_inReady <= 1'b1;
                    if (r_inReady && in_valid) begin
                        for (int i = 0; i < LANES; i++) begin
                            r_val[i] <= w_in[i];
                            r_acc[i] <= '0;
                        end
                        r_k       <= 3'd0;
                        r_inReady <= 1'b0;
                        r_state   <= SCALE;
                    end
                end
                SCALE: begin
                    for (int i = 0; i < LANES; i++) begin
                        r_acc[i] <= w_accNext[i];
                    end
                    r_k <= r_k + 3'd1;
                    if (r_k == 3'd6) begin
                        for (int i = 0; i < LANES; i++) begin
                            r_res[i] <= w_round[i];
                        end
                        r_outValid <= 1'b1;
                        r_state    <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_inReady  <= 1'b1;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign x_out0    = r_res[0];
    assign x_out1    = r_res[1];
    assign x_out2    = r_res[2];
    assign x_out3    = r_res[3];
    assign y_out0    = r_res[4];
    assign y_out1    = r_res[5];
    assign y_out2    = r_res[6];
    assign y_out3    = r_res[7];

endmodule
